// File: rtl/pixel_packer.sv
// Packs 4-bit rasterizer pixels into sof-tagged bytes and queues them in an 8-deep show-ahead FIFO.
// Optional build macro: PIXEL_PACKER_DROP_CNT_EN enables the saturating dropped-byte counter.
module pixel_packer (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] pixel_data,
    input  logic       pixel_en,
    input  logic       frame_sync,
    output logic [7:0] out_data,
    output logic       out_sof,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] fifo_count,
    output logic       overflow,
    output logic       frame_done,
    output logic [7:0] drop_count
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } asm_state_t;

    asm_state_t state;
    asm_state_t next_state;

    logic [3:0] high_nib;
    logic       pending_sof;
    logic [5:0] pix_idx;

    logic       restart;
    logic       load_high;
    logic       push;
    logic [8:0] push_word;

    logic [8:0] mem [0:7];
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] count;
    logic       full;
    logic       pop;
    logic       write_en;
    logic       drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (pixel_en) begin
            if (frame_sync) begin
                next_state = LO;
            end else begin
                case (state)
                    HI:      next_state = LO;
                    LO:      next_state = HI;
                    default: next_state = state;
                endcase
            end
        end
    end

    // A sync pixel restarts the frame from any state and wins over a pending byte.
    always_comb begin
        restart   = 1'b0;
        load_high = 1'b0;
        push      = 1'b0;
        if (pixel_en) begin
            if (frame_sync) begin
                restart = 1'b1;
            end else begin
                load_high = (state == HI);
                push      = (state == LO);
            end
        end
    end

    assign push_word = {pending_sof, high_nib, pixel_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_nib    <= 4'h0;
            pending_sof <= 1'b0;
            pix_idx     <= 6'd0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= push && (pix_idx == 6'd63);
            if (restart) begin
                high_nib    <= pixel_data;
                pending_sof <= 1'b1;
                pix_idx     <= 6'd1;
            end else if (load_high) begin
                high_nib <= pixel_data;
                pix_idx  <= pix_idx + 6'd1;
            end else if (push) begin
                pending_sof <= 1'b0;
                pix_idx     <= pix_idx + 6'd1;
            end
        end
    end

    // A pop frees the head slot in the same cycle, so a push into a full FIFO is kept when popping.
    assign full     = (count == 4'd8);
    assign pop      = out_valid && out_ready;
    assign write_en = push && (!full || pop);
    assign drop     = push && full && !pop;

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= 3'd0;
            rd_ptr   <= 3'd0;
            count    <= 4'd0;
            overflow <= 1'b0;
        end else begin
            if (write_en) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            if (write_en && !pop) begin
                count <= count + 4'd1;
            end else if (pop && !write_en) begin
                count <= count - 4'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef PIXEL_PACKER_DROP_CNT_EN
    logic [7:0] drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = 8'd0;
`endif

    // Head word is gated by out_valid so the outputs read zero while empty or in reset.
    assign out_valid  = (count != 4'd0);
    assign fifo_count = count;
    assign out_data   = out_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign out_sof    = out_valid ? mem[rd_ptr][8] : 1'b0;

endmodule

// File: tb/tb_pixel_packer.sv
// Directed self-checking bench for pixel_packer; expected drop_count follows PIXEL_PACKER_DROP_CNT_EN.
module tb_pixel_packer;

    logic       clk;
    logic       rst;
    logic [3:0] pixel_data;
    logic       pixel_en;
    logic       frame_sync;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       frame_done;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;

`ifdef PIXEL_PACKER_DROP_CNT_EN
    localparam int EXP_DROPS = 2;
`else
    localparam int EXP_DROPS = 0;
`endif

    pixel_packer dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_data (pixel_data),
        .pixel_en   (pixel_en),
        .frame_sync (frame_sync),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .frame_done (frame_done),
        .drop_count (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs seen right after reflect the previous rising edge.
    task automatic applyStimulus(input logic en, input logic sync, input logic [3:0] data);
        @(negedge clk);
        pixel_en   = en;
        frame_sync = sync;
        pixel_data = data;
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        pixel_en   = 1'b0;
        frame_sync = 1'b0;
        pixel_data = 4'h0;
        rst = 1'b0;
    endtask

    function automatic logic [7:0] expByte(input int k);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(2 * k);
        lo = 4'(2 * k + 1);
        return {hi, lo};
    endfunction

    initial begin
        int bytes_seen;
        int sof_count;
        int fd_count;
        int fd_at;
        logic first_sof;

        rst        = 1'b1;
        pixel_en   = 1'b0;
        frame_sync = 1'b0;
        pixel_data = 4'h0;
        out_ready  = 1'b0;

        // Reset state and two-byte frame with a free-running consumer
        @(negedge clk);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", 32'(out_data), 32'h00);
        checkOutput("rst_count", 32'(fifo_count), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        checkOutput("rst_fdone", 32'(frame_done), 32'd0);
        checkOutput("rst_drops", 32'(drop_count), 32'd0);
        doReset();
        out_ready = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'h1);
        applyStimulus(1'b1, 1'b0, 4'h2);
        applyStimulus(1'b1, 1'b0, 4'h3);
        checkOutput("b0_valid", 32'(out_valid), 32'd1);
        checkOutput("b0_data", 32'(out_data), 32'h12);
        checkOutput("b0_sof", 32'(out_sof), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'h4);
        checkOutput("b0_popped", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("b1_valid", 32'(out_valid), 32'd1);
        checkOutput("b1_data", 32'(out_data), 32'h34);
        checkOutput("b1_sof", 32'(out_sof), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("b1_popped", 32'(fifo_count), 32'd0);

        // Pixels before the first sync are ignored
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'hF);
        applyStimulus(1'b1, 1'b1, 4'hA);
        checkOutput("hunt_count", 32'(fifo_count), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'hB);
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("hunt_one", 32'(fifo_count), 32'd1);
        checkOutput("hunt_data", 32'(out_data), 32'hAB);
        checkOutput("hunt_sof", 32'(out_sof), 32'd1);
        out_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("hunt_drain", 32'(fifo_count), 32'd0);

        // Full 64-pixel frame streamed straight through
        doReset();
        out_ready  = 1'b1;
        bytes_seen = 0;
        sof_count  = 0;
        fd_count   = 0;
        fd_at      = -1;
        first_sof  = 1'b0;
        for (int i = 0; i < 67; i++) begin
            if (i < 64) applyStimulus(1'b1, (i == 0), 4'(i));
            else        applyStimulus(1'b0, 1'b0, 4'h0);
            if (out_valid) begin
                checkOutput("frm_byte", 32'(out_data), 32'(expByte(bytes_seen)));
                if (bytes_seen == 0) first_sof = out_sof;
                if (out_sof) sof_count++;
                bytes_seen++;
            end
            if (frame_done) begin
                fd_count++;
                fd_at = bytes_seen;
            end
        end
        checkOutput("frm_bytes", 32'(bytes_seen), 32'd32);
        checkOutput("frm_first_sof", 32'(first_sof), 32'd1);
        checkOutput("frm_sof_total", 32'(sof_count), 32'd1);
        checkOutput("frm_fdone_cnt", 32'(fd_count), 32'd1);
        checkOutput("frm_fdone_at", 32'(fd_at), 32'd32);

        // Stalled consumer: fill, overflow, then drain in order
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, (i == 0), 4'(i));
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("ovf_count", 32'(fifo_count), 32'd8);
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_drops", 32'(drop_count), 32'(EXP_DROPS));
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            checkOutput("drain_data", 32'(out_data), 32'(expByte(j)));
            checkOutput("drain_sof", 32'(out_sof), 32'(j == 0));
            applyStimulus(1'b0, 1'b0, 4'h0);
        end
        checkOutput("drain_empty", 32'(out_valid), 32'd0);
        checkOutput("drain_ovf_sticky", 32'(overflow), 32'd1);

        // Resync while a high nibble is held
        doReset();
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'h5);
        applyStimulus(1'b1, 1'b0, 4'h6);
        applyStimulus(1'b1, 1'b0, 4'h7);
        applyStimulus(1'b1, 1'b1, 4'h8);
        applyStimulus(1'b1, 1'b0, 4'h9);
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("rsync_count", 32'(fifo_count), 32'd2);
        checkOutput("rsync_b0", 32'(out_data), 32'h56);
        out_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("rsync_b1", 32'(out_data), 32'h89);
        checkOutput("rsync_b1_sof", 32'(out_sof), 32'd1);

        // Push and pop together while full, then asynchronous reset mid-frame
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, (i == 0), 4'(i));
        applyStimulus(1'b1, 1'b0, 4'hA);
        checkOutput("full_count", 32'(fifo_count), 32'd8);
        applyStimulus(1'b1, 1'b0, 4'hB);
        out_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0);
        out_ready = 1'b0;
        checkOutput("pp_count", 32'(fifo_count), 32'd8);
        checkOutput("pp_no_ovf", 32'(overflow), 32'd0);
        checkOutput("pp_head", 32'(out_data), 32'h23);
        applyStimulus(1'b1, 1'b0, 4'hC);
        applyStimulus(1'b1, 1'b0, 4'hD);
        applyStimulus(1'b1, 1'b1, 4'h3);
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("pre_rst_ovf", 32'(overflow), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_sof", 32'(out_sof), 32'd0);
        checkOutput("arst_data", 32'(out_data), 32'h00);
        checkOutput("arst_count", 32'(fifo_count), 32'd0);
        checkOutput("arst_ovf", 32'(overflow), 32'd0);
        checkOutput("arst_fdone", 32'(frame_done), 32'd0);
        checkOutput("arst_drops", 32'(drop_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'h4);
        applyStimulus(1'b1, 1'b0, 4'h5);
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("post_rst_empty", 32'(fifo_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
